// File: rtl/skip_add_pkg.sv
// Shared types and constants for the skip-adder accumulator.
// Holds the FSM state enum, data width and default parameters.
package skip_add_pkg;

  localparam int DATA_W    = 32;
  localparam int SETTLE_DF = 2;
  localparam int CNT_W_DF  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_IN = 2'd1,
    ADD     = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/skip_adder8.sv
// 32-bit carry-skip adder built from four 8-bit ripple blocks.
// Ports: a, b, ci in; s (sum), co (carry-out) out.
module skip_adder8
  import skip_add_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              ci,
  output logic [DATA_W-1:0] s,
  output logic              co
);

  logic [8:0] w_r;
  logic       w_p;
  logic       w_c;

  // A block whose bits all propagate passes its carry-in straight
  // through, bypassing the ripple path.
  always_comb begin
    w_c = ci;
    w_r = '0;
    w_p = 1'b0;
    s   = '0;
    for (int k = 0; k < DATA_W / 8; k++) begin
      w_r = {1'b0, a[8*k +: 8]}
          + {1'b0, b[8*k +: 8]}
          + 9'(w_c);
      w_p = &(a[8*k +: 8] ^ b[8*k +: 8]);
      s[8*k +: 8] = w_r[7:0];
      w_c = w_p ? w_c : w_r[8];
    end
    co = w_c;
  end

endmodule

// File: rtl/skip_add_accum.sv
// Streaming accumulator around skip_adder8 with multicycle settle.
// Ports: start/len/init/cin_first job setup; in_* operand stream;
// out_* result handshake (sum, carry, ovf count); busy.
module skip_add_accum
  import skip_add_pkg::*;
#(
  parameter int SETTLE = SETTLE_DF,
  parameter int CNT_W  = CNT_W_DF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic [DATA_W-1:0] init,
  input  logic              cin_first,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic [CNT_W-1:0]  out_ovf_cnt,
  output logic              busy
);

  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0] SLOAD = SW'(SETTLE - 1);

  state_t            r_state;
  state_t            w_nxt;
  logic [DATA_W-1:0] r_acc;
  logic [DATA_W-1:0] r_opb;
  logic [CNT_W-1:0]  r_rem;
  logic [SW-1:0]     r_settle;
  logic [CNT_W-1:0]  r_ovf;
  logic              r_last_co;
  logic              r_ci_pend;
  logic [DATA_W-1:0] w_s;
  logic              w_co;

  // Adder inputs are registers only, so they stay frozen while
  // the skip chain settles.
  skip_adder8 u_add (
    .a  (r_acc),
    .b  (r_opb),
    .ci (r_ci_pend),
    .s  (w_s),
    .co (w_co)
  );

  always_comb begin
    w_nxt     = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start)
          w_nxt = (len == '0) ? DONE : WAIT_IN;
      end
      WAIT_IN: begin
        in_ready = 1'b1;
        if (in_valid)
          w_nxt = ADD;
      end
      ADD: begin
        if (r_settle == '0)
          w_nxt = (r_rem == CNT_W'(1)) ? DONE : WAIT_IN;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready)
          w_nxt = IDLE;
      end
      default: w_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_acc     <= '0;
      r_opb     <= '0;
      r_rem     <= '0;
      r_settle  <= '0;
      r_ovf     <= '0;
      r_last_co <= 1'b0;
      r_ci_pend <= 1'b0;
    end else begin
      r_state <= w_nxt;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_acc     <= init;
            r_rem     <= len;
            r_ovf     <= '0;
            r_last_co <= 1'b0;
            r_ci_pend <= cin_first;
          end
        end
        WAIT_IN: begin
          if (in_valid) begin
            r_opb    <= in_data;
            r_settle <= SLOAD;
          end
        end
        ADD: begin
          if (r_settle != '0) begin
            r_settle <= r_settle - SW'(1);
          end else begin
            r_acc     <= w_s;
            r_last_co <= w_co;
            r_ci_pend <= 1'b0;
            r_rem     <= r_rem - CNT_W'(1);
            if (w_co && (r_ovf != '1))
              r_ovf <= r_ovf + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_sum     = r_acc;
  assign out_carry   = r_last_co;
  assign out_ovf_cnt = r_ovf;

endmodule

// File: tb/tb_skip_add_accum.sv
// Scoreboard bench for skip_add_accum.
// Directed jobs push expected results; a monitor checks them.
module tb_skip_add_accum;

  localparam int SETTLE = 2;
  localparam int CNT_W  = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [CNT_W-1:0] len;
  logic [31:0]      init;
  logic             cin_first;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_sum;
  logic             out_carry;
  logic [CNT_W-1:0] out_ovf_cnt;
  logic             busy;

  typedef struct {
    logic [31:0]      s;
    logic             c;
    logic [CNT_W-1:0] o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  skip_add_accum #(.SETTLE(SETTLE), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .len         (len),
    .init        (init),
    .cin_first   (cin_first),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_carry   (out_carry),
    .out_ovf_cnt (out_ovf_cnt),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_unexpected got=%0h want=none", out_sum);
      end else begin
        e = q.pop_front();
        chk("sum", out_sum, e.s);
        chk("carry", 32'(out_carry), 32'(e.c));
        chk("ovf", 32'(out_ovf_cnt), 32'(e.o));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_res(input logic [31:0] s,
                            input logic c,
                            input logic [CNT_W-1:0] o);
    exp_t e;
    e.s = s;
    e.c = c;
    e.o = o;
    q.push_back(e);
  endtask

  task automatic start_job(input logic [31:0] i,
                           input logic [CNT_W-1:0] l,
                           input logic ci);
    start     = 1'b1;
    init      = i;
    len       = l;
    cin_first = ci;
    tick();
    start     = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input int gap);
    int n;
    n = 0;
    repeat (gap) begin
      chk("rdy_gap", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b1;
    in_data  = d;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL hs_timeout got=0 want=1");
    end
    tick();
    in_valid = 1'b0;
    in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < SETTLE; i++) begin
      chk("rdy_add", 32'(in_ready), 32'd0);
      tick();
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    if (!out_valid) begin
      checks++;
      errors++;
      $display("FAIL done_timeout got=0 want=1");
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst       = 1'b1;
    start     = 1'b0;
    len       = '0;
    init      = '0;
    cin_first = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    chk("rst_ov", 32'(out_valid), 32'd0);
    chk("rst_sum", out_sum, 32'd0);
    chk("rst_ovf", 32'(out_ovf_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Operand waiting at start: latency 1 + 1*(1+SETTLE).
    in_valid = 1'b1;
    in_data  = 32'd15;
    expect_res(32'd16, 1'b0, '0);
    start_job(32'd0, 8'd1, 1'b1);
    n = 1;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("lat_len1", 32'(n), 32'(1 + (1 + SETTLE)));
    in_valid = 1'b0;
    tick();

    expect_res(32'd16, 1'b0, '0);
    start_job(32'd5, 8'd1, 1'b1);
    send(32'd10, 0);
    wait_done();

    expect_res(32'd210, 1'b0, '0);
    start_job(32'd0, 8'd3, 1'b0);
    send(32'd37, 3);
    send(32'd48, 3);
    send(32'd125, 3);
    wait_done();

    expect_res(32'hFFFF_FFFF, 1'b0, 8'd1);
    start_job(32'hFFFF_FFFF, 8'd2, 1'b0);
    send(32'd1, 0);
    send(32'hFFFF_FFFF, 1);
    wait_done();

    // cin_first must apply only to the first add.
    expect_res(32'd4, 1'b0, '0);
    start_job(32'd0, 8'd2, 1'b1);
    send(32'd1, 0);
    send(32'd2, 0);
    wait_done();

    expect_res(32'd127, 1'b0, '0);
    start_job(32'd127, 8'd0, 1'b1);
    chk("lat_len0", 32'(out_valid), 32'd1);
    tick();
    chk("idle_len0", 32'(busy), 32'd0);

    // Backpressure with a start pulse during DONE.
    out_ready = 1'b0;
    expect_res(32'd77777, 1'b0, '0);
    start_job(32'd70000, 8'd1, 1'b1);
    send(32'd7776, 0);
    for (int i = 0; i < 5; i++) begin
      chk("hold_ov", 32'(out_valid), 32'd1);
      chk("hold_sum", out_sum, 32'd77777);
      start = (i == 2);
      len   = '0;
      init  = 32'd5;
      tick();
    end
    start     = 1'b1;
    init      = 32'd9;
    len       = '0;
    out_ready = 1'b1;
    tick();
    start = 1'b0;
    chk("drop_busy", 32'(busy), 32'd0);
    chk("drop_ov", 32'(out_valid), 32'd0);
    chk("keep_sum", out_sum, 32'd77777);
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Reset in the middle of an add abandons the job.
    start_job(32'd1, 8'd4, 1'b0);
    in_valid = 1'b1;
    in_data  = 32'd3;
    tick();
    in_valid = 1'b0;
    chk("add_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_rdy", 32'(in_ready), 32'd0);
    chk("mid_ov", 32'(out_valid), 32'd0);
    chk("mid_sum", out_sum, 32'd0);
    chk("mid_c", 32'(out_carry), 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_busy", 32'(busy), 32'd0);

    expect_res(32'd21001, 1'b0, '0);
    start_job(32'd16000, 8'd1, 1'b1);
    send(32'd5000, 0);
    wait_done();
    tick();

    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
